shifter_operand_unit: RTL and testbench
=======================================

// Module: shifter_operand_unit
// PURPOSE
//   Parametrised, pipelined successor to the EXE-stage operand-2 generator.
//   Produces ALU operand 2 and the shifter carry-out for the ARM data-processing modes:
//   rotated immediate, immediate-amount shift, register-amount shift (Rs) and RRX.
//   Also produces the LDR/STR 12-bit offset.
//   Two-stage elastic pipeline with valid/ready handshake and a synchronous flush.
//   Sits between ID/EXE operand fetch and the ALU/status-register path.
// PARAMETERS
//   WIDTH         32  datapath width; power of two, >= 16
//   OFFSET_W      12  memory offset / shift_operand field width
//   MEM_SIGN_EXT  1   1: sign-extend memory offset; 0: zero-extend
// PORTS
//   clk            in   1         rising-edge clock
//   rst            in   1         synchronous, active-high reset
//   flush          in   1         synchronous pipeline kill (branch taken)
//   in_valid       in   1         request valid
//   in_ready       out  1         unit accepts request this cycle
//   rm_val         in   WIDTH     Rm register value
//   rs_val         in   8         Rs[7:0], shift amount for register shifts
//   imm            in   1         I bit: rotated-immediate operand
//   mem_cmd        in   1         LDR/STR offset mode (highest priority)
//   reg_shift      in   1         shift amount taken from rs_val; shift_operand[4] is ignored
//   shift_operand  in   OFFSET_W  instruction operand field [11:0]
//   carry_in       in   1         current C flag
//   out_valid      out  1         result valid
//   out_ready      in   1         consumer accepts result
//   val2           out  WIDTH     operand 2
//   carry_out      out  1         shifter carry-out
// BEHAVIOUR
//   Reset: out_valid=0, val2=0, carry_out=0, both stage valids cleared.
//   in_ready=0 while rst=1, and 1 in the first cycle after reset.
//   Pipeline: stage A registers inputs, decodes mode and computes effective amount n.
//   Stage B registers val2/carry_out.
//   Latency: exactly 2 cycles from the accepting edge when out_ready=1.
//   Throughput: 1 result per cycle.
//   Handshake:
//   - Accept on in_valid & in_ready.
//   - in_ready = !A_valid | (A moves to B).
//   - A moves to B when !B_valid | out_ready.
//   - While out_valid & !out_ready, val2 and carry_out are held stable.
//   - No request is dropped or duplicated.
//   flush: at the next edge clears A_valid and B_valid; any same-cycle accept is discarded.
//   flush=1 forces in_ready=0. rst has priority over flush.
//   Mode priority: mem_cmd > imm > register/immediate shift.
//   mem_cmd:
//   - val2 = shift_operand extended to WIDTH per MEM_SIGN_EXT.
//   - carry_out = carry_in.
//   imm:
//   - val2 = ROR(zext(so[7:0]), 2*so[11:8]).
//   - carry_out = carry_in if so[11:8]==0, else val2[WIDTH-1].
//   Shift type t = so[6:5] (00 LSL, 01 LSR, 10 ASR, 11 ROR).
//   Immediate amount (reg_shift=0), n = so[11:7]:
//   - LSL #0: val2=Rm, carry_out=carry_in.
//   - LSR #0 means LSR #32: val2=0, carry_out=Rm[W-1].
//   - ASR #0 means ASR #32: val2 = {W{Rm[W-1]}}, carry_out=Rm[W-1].
//   - ROR #0 means RRX: val2 = {carry_in, Rm[W-1:1]}, carry_out=Rm[0].
//   Register amount (reg_shift=1), n = rs_val (0..255):
//   - n==0: val2=Rm, carry_out=carry_in, for all types.
//   - LSL: n<W -> Rm<<n, carry_out=Rm[W-n]; n==W -> 0, Rm[0]; n>W -> 0, 0.
//   - LSR: n<W -> Rm>>n, carry_out=Rm[n-1]; n==W -> 0, Rm[W-1]; n>W -> 0, 0.
//   - ASR: n>=W -> all sign bits, carry_out=Rm[W-1]; else arithmetic shift, carry_out=Rm[n-1].
//   - ROR: k = n mod W; k==0 -> val2=Rm, carry_out=Rm[W-1]; else ROR by k, carry_out=Rm[k-1].
//   Amounts > 32 for immediate rotate wrap mod WIDTH.
//   The shift is combinational, single cycle in stage B; no iterative loops.
// TESTING
//   1. imm=1, so=0x4FF, cin=0 -> val2=0xFF000000, cout=1, out_valid 2 cycles after accept.
//   2. reg_shift=0, so=LSR #0 (0x020), Rm=0x80000001 -> val2=0, cout=1; RRX (so=0x060), cin=1 -> val2=0xC0000000, cout=1.
//   3. reg_shift=1, LSL, rs=32, Rm=0x00000001 -> val2=0, cout=1; rs=33 -> val2=0, cout=0; rs=0, cin=1 -> val2=Rm, cout=1.
//   4. reg_shift=1, ROR, rs=36, Rm=0x0000000F -> val2=0xF0000000, cout=1; rs=64 -> val2=Rm, cout=0.
//   5. mem_cmd=1, so=0xFFC -> val2=0xFFFFFFFC (MEM_SIGN_EXT=1) / 0x00000FFC (=0); imm=1 is ignored.
//   6. Stream 6 back-to-back requests with out_ready toggling; flush mid-stream; rst mid-stream
//      -> results match a reference model in order, held outputs stable while stalled,
//         flushed and in-flight items never appear, out_valid=0 after reset.

Source files
------------

// File: rtl/shifter_operand_unit.sv
// Operand-2 generator for ARM data-processing and LDR/STR offsets.
// Stage A decodes the mode and effective amount, stage B runs the barrel shift and holds the result.
module shifter_operand_unit #(
    parameter int WIDTH        = 32,
    parameter int OFFSET_W     = 12,
    parameter bit MEM_SIGN_EXT = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WIDTH-1:0]    rm_val,
    input  logic [7:0]          rs_val,
    input  logic                imm,
    input  logic                mem_cmd,
    input  logic                reg_shift,
    input  logic [OFFSET_W-1:0] shift_operand,
    input  logic                carry_in,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WIDTH-1:0]    val2,
    output logic                carry_out
);

    localparam int LW = $clog2(WIDTH);
    localparam int NW = (LW + 1 > 9) ? LW + 1 : 9;

    // Every mode collapses onto one of these; mem offsets and LSL #0 are LSL by zero.
    typedef enum logic [2:0] {K_LSL, K_LSR, K_ASR, K_ROR, K_RRX} kind_t;

    logic                    vld_p0;
    logic                    vld_p1;
    kind_t                   kind_p0;
    logic [NW-1:0]           n_p0;
    logic signed [WIDTH-1:0] opnd_p0;
    logic                    cin_p0;

    kind_t                   dec_kind;
    logic [NW-1:0]           dec_n;
    logic signed [WIDTH-1:0] dec_opnd;
    logic [WIDTH:0]          b_res;
    logic                    a_move;
    logic                    accept;

    function automatic logic [WIDTH-1:0] ext_offset(input logic [OFFSET_W-1:0] off);
        logic [WIDTH-1:0] res;
        if (MEM_SIGN_EXT)
            res = {{(WIDTH-OFFSET_W){off[OFFSET_W-1]}}, off};
        else
            res = {{(WIDTH-OFFSET_W){1'b0}}, off};
        return res;
    endfunction

    // Returns {carry, value}. A guard bit next to the operand captures the last bit shifted out.
    function automatic logic [WIDTH:0] shift_op(input kind_t kind, input logic [NW-1:0] n,
                                                input logic signed [WIDTH-1:0] opnd,
                                                input logic cin);
        logic [WIDTH:0]          res;
        logic [WIDTH:0]          lsl_t;
        logic [WIDTH:0]          lsr_t;
        logic signed [WIDTH:0]   asr_t;
        logic [2*WIDTH-1:0]      dbl;
        logic [LW-1:0]           k;
        logic [NW-1:0]           nc;
        res = {cin, opnd};
        if (kind == K_RRX) begin
            res = {opnd[0], cin, opnd[WIDTH-1:1]};
        end else if (n != '0) begin
            case (kind)
                K_LSL: begin
                    lsl_t = {1'b0, opnd} << n;
                    res   = lsl_t;
                end
                K_LSR: begin
                    lsr_t = {opnd, 1'b0} >> n;
                    res   = {lsr_t[0], lsr_t[WIDTH:1]};
                end
                K_ASR: begin
                    nc    = (n > NW'(WIDTH)) ? NW'(WIDTH) : n;
                    asr_t = $signed({opnd, 1'b0}) >>> nc;
                    res   = {asr_t[0], asr_t[WIDTH:1]};
                end
                default: begin
                    k = n[LW-1:0];
                    if (k == '0) begin
                        res = {opnd[WIDTH-1], opnd};
                    end else begin
                        dbl = {opnd, opnd} >> k;
                        res = {dbl[WIDTH-1], dbl[WIDTH-1:0]};
                    end
                end
            endcase
        end
        return res;
    endfunction

    always_comb begin
        dec_kind = K_LSL;
        dec_n    = '0;
        dec_opnd = rm_val;
        if (mem_cmd) begin
            dec_opnd = ext_offset(shift_operand);
        end else if (imm) begin
            dec_kind = K_ROR;
            dec_n    = NW'({shift_operand[11:8], 1'b0});
            dec_opnd = WIDTH'(shift_operand[7:0]);
        end else if (reg_shift) begin
            dec_kind = kind_t'({1'b0, shift_operand[6:5]});
            dec_n    = NW'(rs_val);
        end else begin
            dec_n = NW'(shift_operand[11:7]);
            case (shift_operand[6:5])
                2'b00: dec_kind = K_LSL;
                2'b01: begin
                    dec_kind = K_LSR;
                    if (shift_operand[11:7] == 5'd0) dec_n = NW'(WIDTH);
                end
                2'b10: begin
                    dec_kind = K_ASR;
                    if (shift_operand[11:7] == 5'd0) dec_n = NW'(WIDTH);
                end
                default: dec_kind = (shift_operand[11:7] == 5'd0) ? K_RRX : K_ROR;
            endcase
        end
    end

    assign a_move    = !vld_p1 || out_ready;
    assign in_ready  = !rst && !flush && (!vld_p0 || a_move);
    assign accept    = in_valid && in_ready;
    assign out_valid = vld_p1;
    assign b_res     = shift_op(kind_p0, n_p0, opnd_p0, cin_p0);

    // Stage A: decoded request
    always_ff @(posedge clk) begin
        if (accept) begin
            kind_p0 <= dec_kind;
            n_p0    <= dec_n;
            opnd_p0 <= dec_opnd;
            cin_p0  <= carry_in;
        end
    end

    // Stage B: shifted result, held while the consumer stalls
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p0    <= 1'b0;
            vld_p1    <= 1'b0;
            val2      <= '0;
            carry_out <= 1'b0;
        end else if (flush) begin
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
        end else begin
            if (a_move) begin
                vld_p1 <= vld_p0;
                if (vld_p0) begin
                    val2      <= b_res[WIDTH-1:0];
                    carry_out <= b_res[WIDTH];
                end
            end
            if (in_ready) vld_p0 <= in_valid;
        end
    end

endmodule

// File: tb/tb_shifter_operand_unit.sv
// Bench for shifter_operand_unit: sign- and zero-extending instances share stimulus
// and are compared each cycle against an in-order reference queue.
module tb_shifter_operand_unit;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, imm, mem_cmd, reg_shift, carry_in, out_ready;
    logic [31:0] rm_val;
    logic [7:0]  rs_val;
    logic [11:0] shift_operand;
    logic        in_ready, out_valid, carry_out;
    logic [31:0] val2;
    logic        in_ready_z, out_valid_z, carry_out_z;
    logic [31:0] val2_z;

    always #5 clk = ~clk;

    shifter_operand_unit #(.WIDTH(32), .OFFSET_W(12), .MEM_SIGN_EXT(1'b1)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .rm_val(rm_val), .rs_val(rs_val), .imm(imm), .mem_cmd(mem_cmd), .reg_shift(reg_shift),
        .shift_operand(shift_operand), .carry_in(carry_in), .out_valid(out_valid),
        .out_ready(out_ready), .val2(val2), .carry_out(carry_out));

    shifter_operand_unit #(.WIDTH(32), .OFFSET_W(12), .MEM_SIGN_EXT(1'b0)) dut_z (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_z),
        .rm_val(rm_val), .rs_val(rs_val), .imm(imm), .mem_cmd(mem_cmd), .reg_shift(reg_shift),
        .shift_operand(shift_operand), .carry_in(carry_in), .out_valid(out_valid_z),
        .out_ready(out_ready), .val2(val2_z), .carry_out(carry_out_z));

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    typedef struct {
        logic [31:0] v;
        logic [31:0] vz;
        logic        c;
    } exp_t;
    exp_t q[$];

    // Reference straight from the ARM operand-2 rules, 32-bit datapath.
    function automatic void model(input logic [31:0] rm, input logic [7:0] rs, input logic im,
                                  input logic mc, input logic rsh, input logic [11:0] so,
                                  input logic cin, input bit sext,
                                  output logic [31:0] v, output logic c);
        int          n;
        logic [63:0] d;
        d = {rm, rm};
        if (mc) begin
            v = sext ? {{20{so[11]}}, so} : {20'd0, so};
            c = cin;
        end else if (im) begin
            n = 2 * so[11:8];
            d = {24'd0, so[7:0], 24'd0, so[7:0]};
            v = 32'(d >> n);
            c = (n == 0) ? cin : v[31];
        end else if (!rsh) begin
            n = so[11:7];
            case (so[6:5])
                2'b00: if (n == 0) begin v = rm; c = cin; end
                       else begin v = rm << n; c = rm[32-n]; end
                2'b01: if (n == 0) begin v = 32'd0; c = rm[31]; end
                       else begin v = rm >> n; c = rm[n-1]; end
                2'b10: if (n == 0) begin v = {32{rm[31]}}; c = rm[31]; end
                       else begin v = $signed(rm) >>> n; c = rm[n-1]; end
                default: if (n == 0) begin v = {cin, rm[31:1]}; c = rm[0]; end
                         else begin v = 32'(d >> n); c = rm[n-1]; end
            endcase
        end else begin
            n = rs;
            if (n == 0) begin
                v = rm; c = cin;
            end else begin
                case (so[6:5])
                    2'b00: if (n < 32) begin v = rm << n; c = rm[32-n]; end
                           else if (n == 32) begin v = 32'd0; c = rm[0]; end
                           else begin v = 32'd0; c = 1'b0; end
                    2'b01: if (n < 32) begin v = rm >> n; c = rm[n-1]; end
                           else if (n == 32) begin v = 32'd0; c = rm[31]; end
                           else begin v = 32'd0; c = 1'b0; end
                    2'b10: if (n >= 32) begin v = {32{rm[31]}}; c = rm[31]; end
                           else begin v = $signed(rm) >>> n; c = rm[n-1]; end
                    default: begin
                        n = n % 32;
                        if (n == 0) begin v = rm; c = rm[31]; end
                        else begin v = 32'(d >> n); c = rm[n-1]; end
                    end
                endcase
            end
        end
    endfunction

    // Compare process: scoreboard, hold stability, reset and flush behaviour.
    bit          prev_stall = 1'b0;
    bit          prev_rst   = 1'b0;
    logic [31:0] held_v;
    logic        held_c;

    always @(negedge clk) begin
        exp_t        e;
        logic [31:0] mv, mvz;
        logic        mc_s, mcz;
        if (prev_stall) begin
            chk("hold_valid", {31'd0, out_valid}, 32'd1);
            chk("hold_val2", val2, held_v);
            chk("hold_cout", {31'd0, carry_out}, {31'd0, held_c});
        end
        if (prev_rst && !rst) begin
            chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
            chk("rst_val2", val2, 32'd0);
            chk("rst_cout", {31'd0, carry_out}, 32'd0);
            chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        end
        if (rst) chk("in_ready_during_rst", {31'd0, in_ready}, 32'd0);
        if (flush) chk("in_ready_during_flush", {31'd0, in_ready}, 32'd0);
        if (out_valid) begin
            if (q.size() == 0) begin
                chk("phantom_out_valid", {31'd0, out_valid}, 32'd0);
            end else begin
                e = q[0];
                chk("val2", val2, e.v);
                chk("cout", {31'd0, carry_out}, {31'd0, e.c});
                chk("val2_zx", val2_z, e.vz);
                chk("out_valid_zx", {31'd0, out_valid_z}, 32'd1);
                if (out_ready) void'(q.pop_front());
            end
        end
        if (in_valid && in_ready) begin
            model(rm_val, rs_val, imm, mem_cmd, reg_shift, shift_operand, carry_in, 1'b1, mv, mc_s);
            model(rm_val, rs_val, imm, mem_cmd, reg_shift, shift_operand, carry_in, 1'b0, mvz, mcz);
            e.v = mv; e.vz = mvz; e.c = mc_s;
            q.push_back(e);
        end
        if (rst || flush) q.delete();
        prev_stall = out_valid && !out_ready && !rst && !flush;
        held_v     = val2;
        held_c     = carry_out;
        prev_rst   = rst;
    end

    task automatic run_one(input string name, input logic [31:0] rm, input logic [7:0] rs,
                           input logic im, input logic mc, input logic rsh, input logic [11:0] so,
                           input logic cin, input logic [31:0] ev, input logic [31:0] evz,
                           input logic ec);
        logic [31:0] mv;
        logic        mc_s;
        int          k;
        model(rm, rs, im, mc, rsh, so, cin, 1'b1, mv, mc_s);
        chk({name, "_model_val2"}, mv, ev);
        chk({name, "_model_cout"}, {31'd0, mc_s}, {31'd0, ec});
        @(posedge clk); #1;
        rm_val = rm; rs_val = rs; imm = im; mem_cmd = mc; reg_shift = rsh;
        shift_operand = so; carry_in = cin; in_valid = 1'b1; out_ready = 1'b1; flush = 1'b0;
        k = 0;
        @(negedge clk);
        while (!in_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!in_ready) chk({name, "_accept_timeout"}, {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk({name, "_lat1_out_valid"}, {31'd0, out_valid}, 32'd0);
        @(posedge clk); #1;
        chk({name, "_lat2_out_valid"}, {31'd0, out_valid}, 32'd1);
        chk({name, "_val2"}, val2, ev);
        chk({name, "_val2_zx"}, val2_z, evz);
        chk({name, "_cout"}, {31'd0, carry_out}, {31'd0, ec});
    endtask

    function automatic logic [7:0] pick_rs();
        case ($urandom_range(0, 5))
            0: return 8'd0;
            1: return 8'd31;
            2: return 8'd32;
            3: return 8'd33;
            4: return 8'(32 * $urandom_range(1, 7));
            default: return 8'($urandom);
        endcase
    endfunction

    task automatic stream(input int cycles, input int valid_pct, input int flush_pct,
                          input int rst_at);
        bit acc_last = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            if (!in_valid || acc_last) begin
                in_valid      = ($urandom_range(0, 99) < valid_pct);
                rm_val        = $urandom;
                rs_val        = pick_rs();
                mem_cmd       = ($urandom_range(0, 7) == 0);
                imm           = ($urandom_range(0, 3) == 0);
                reg_shift     = $urandom_range(0, 1);
                shift_operand = 12'($urandom);
                carry_in      = $urandom_range(0, 1);
            end
            out_ready = ($urandom_range(0, 2) != 0);
            rst       = (i == rst_at);
            flush     = (i != rst_at + 1) && ($urandom_range(0, 99) < flush_pct);
            @(negedge clk);
            acc_last = in_valid && in_ready;
        end
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; imm = 1'b0; mem_cmd = 1'b0;
        reg_shift = 1'b0; carry_in = 1'b0; out_ready = 1'b1;
        rm_val = '0; rs_val = '0; shift_operand = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        run_one("imm_rot",  32'h12345678, 8'd0,  1, 0, 0, 12'h4FF, 0, 32'hFF000000, 32'hFF000000, 1);
        run_one("lsr0",     32'h80000001, 8'd0,  0, 0, 0, 12'h020, 0, 32'h00000000, 32'h00000000, 1);
        run_one("rrx",      32'h80000001, 8'd0,  0, 0, 0, 12'h060, 1, 32'hC0000000, 32'hC0000000, 1);
        run_one("asr0",     32'h80000000, 8'd0,  0, 0, 0, 12'h040, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1);
        run_one("lsl_imm4", 32'hF0000001, 8'd0,  0, 0, 0, 12'h200, 0, 32'h00000010, 32'h00000010, 1);
        run_one("lsl_rs32", 32'h00000001, 8'd32, 0, 0, 1, 12'h010, 0, 32'h00000000, 32'h00000000, 1);
        run_one("lsl_rs33", 32'h00000001, 8'd33, 0, 0, 1, 12'h010, 0, 32'h00000000, 32'h00000000, 0);
        run_one("lsl_rs0",  32'h00000001, 8'd0,  0, 0, 1, 12'h010, 1, 32'h00000001, 32'h00000001, 1);
        run_one("ror_rs36", 32'h0000000F, 8'd36, 0, 0, 1, 12'h070, 0, 32'hF0000000, 32'hF0000000, 1);
        run_one("ror_rs64", 32'h0000000F, 8'd64, 0, 0, 1, 12'h070, 0, 32'h0000000F, 32'h0000000F, 0);
        run_one("mem_off",  32'h12345678, 8'd0,  1, 1, 0, 12'hFFC, 1, 32'hFFFFFFFC, 32'h00000FFC, 1);

        stream(12, 100, 0, -10);
        stream(150, 100, 5, 70);
        stream(300, 60, 3, 200);

        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0; rst = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("drain_queue_empty", 32'(q.size()), 32'd0);
        chk("drain_out_valid", {31'd0, out_valid}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, passed %0d of %0d", n_pass, n_total);
        $fatal(1);
    end

endmodule
